// File: rtl/alu_exec_unit.sv
// alu_exec_unit: two-stage valid/ready ALU.
//   S1 registers the operands and opcode; S2 registers the result, zero flag
//   and illegal flag. A full pipeline sustains one op per cycle.
// Optional feature macro: ALU_SHIFT_EN adds sll/srl/sra on codes 100/110/111.
// When the macro is undefined, those codes are reported as illegal and no
// shifter is built.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Illegal,
  output logic [15:0]      op_count
);

`ifdef ALU_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);
`endif

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ill;
  } rsp_t;

  req_t s1_q;
  rsp_t s2_q, s2_d;
  logic s1_vld, s2_vld;
  logic in_fire, out_fire, s1_adv;

  // Handshake: S1 drains into S2 whenever S2 is empty or emptying this cycle,
  // so S1 can refill in the same cycle without a bubble.
  assign out_fire = s2_vld & out_ready;
  assign s1_adv   = s1_vld & (~s2_vld | out_ready);
  assign in_ready = ~s1_vld | s1_adv;
  assign in_fire  = in_valid & in_ready;

  // Result computation from the S1 operands; unsupported codes yield 0 and flag illegal
  always_comb begin
    s2_d = '0;
    unique case (s1_q.op)
      3'b000: s2_d.res = s1_q.a + s1_q.b;
      3'b001: s2_d.res = s1_q.a - s1_q.b;
      3'b010: s2_d.res = s1_q.a & s1_q.b;
      3'b011: s2_d.res = s1_q.a | s1_q.b;
      3'b101: s2_d.res = {{(WIDTH-1){1'b0}}, ($signed(s1_q.a) < $signed(s1_q.b))};
`ifdef ALU_SHIFT_EN
      3'b100: s2_d.res = s1_q.a << s1_q.b[SHW-1:0];
      3'b110: s2_d.res = s1_q.a >> s1_q.b[SHW-1:0];
      3'b111: s2_d.res = WIDTH'($signed(s1_q.a) >>> s1_q.b[SHW-1:0]);
`endif
      default: s2_d.ill = 1'b1;
    endcase
    s2_d.zero = (s2_d.res == '0);
  end

  // S1: operand capture, only on an input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else begin
      if (in_fire) begin
        s1_vld <= 1'b1;
        s1_q   <= '{a: SrcA, b: SrcB, op: ALUControl};
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
    end
  end

  // S2: result register, held while stalled by downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_q   <= '0;
    end else begin
      if (s1_adv) begin
        s2_vld <= 1'b1;
        s2_q   <= s2_d;
      end else if (out_fire) begin
        s2_vld <= 1'b0;
      end
    end
  end

  // Consumed-result counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count <= '0;
    else if (out_fire) op_count <= op_count + 16'd1;
  end

  assign out_valid = s2_vld;
  assign ALUResult = s2_q.res;
  assign Zero      = s2_vld & s2_q.zero;
  assign Illegal   = s2_q.ill;

endmodule
